// File: rtl/rgb2hsv_pkg.sv
// Shared constants, types and helpers for the RGB to HSV pipeline.
package rgb2hsv_pkg;

    localparam int unsigned LAT   = 4;
    localparam int unsigned HUE_W = 9;

    localparam logic [HUE_W-1:0] HUE_60  = 9'd60;
    localparam logic [HUE_W-1:0] HUE_120 = 9'd120;
    localparam logic [HUE_W-1:0] HUE_240 = 9'd240;
    localparam logic [HUE_W-1:0] HUE_360 = 9'd360;

    // Which channel holds the maximum (ties resolve R, then G, then B).
    typedef enum logic [1:0] {
        SelR = 2'd0,
        SelG = 2'd1,
        SelB = 2'd2
    } max_sel_e;

    // Map hue 0..359 onto a dw-bit display range; 359 and above pin to full scale.
    function automatic logic [31:0] hue_scale(input logic [HUE_W-1:0] h, input int unsigned dw);
        logic [31:0] num;
        num = 32'(h) << dw;
        if (h >= (HUE_360 - 9'd1)) begin
            hue_scale = (32'd1 << dw) - 32'd1;
        end else begin
            hue_scale = num / 32'd360;
        end
    endfunction

endpackage

// File: rtl/rgb2hsv_pipe_band_stats.sv
// Hue band classification: frame-shadowed bounds, priority band compare,
// last-hit hue hold and (with RGB2HSV_BAND_STATS_EN) per-frame pixel counters.
module hsv_band_stats
    import rgb2hsv_pkg::*;
#(
    parameter int unsigned HUE_BANDS = 3,
    parameter int unsigned CNT_W     = 22
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vsync,
    input  logic [HUE_BANDS*HUE_W-1:0]   band_lo,
    input  logic [HUE_BANDS*HUE_W-1:0]   band_hi,
    input  logic                         cmp_de,
    input  logic [HUE_W-1:0]             cmp_hue,
    input  logic [HUE_W-1:0]             hue,
    input  logic                         out_vsync,
    input  logic                         out_de,
    output logic [HUE_BANDS-1:0]         band_hit,
    output logic [HUE_BANDS*HUE_W-1:0]   band_last_hue,
    output logic [HUE_BANDS*CNT_W-1:0]   band_count,
    output logic                         stats_valid
);

    logic                       vs_prev_q;
    logic [HUE_BANDS*HUE_W-1:0] lo_q;
    logic [HUE_BANDS*HUE_W-1:0] hi_q;
    logic [HUE_BANDS-1:0]       hit_d;
    logic                       found;
    logic [HUE_W-1:0]           lo;
    logic [HUE_W-1:0]           hi;

    // Capture bounds only at the input frame start so a frame sees one band set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev_q <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
        end else begin
            vs_prev_q <= in_vsync;
            if (in_vsync && !vs_prev_q) begin
                lo_q <= band_lo;
                hi_q <= band_hi;
            end
        end
    end

    // Strict-bound compare; lowest matching band wins to keep the result one-hot.
    always_comb begin
        hit_d = '0;
        found = 1'b0;
        lo    = '0;
        hi    = '0;
        for (int i = 0; i < HUE_BANDS; i++) begin
            lo = lo_q[i*HUE_W +: HUE_W];
            hi = hi_q[i*HUE_W +: HUE_W];
            if (cmp_de && !found && (cmp_hue > lo) && (cmp_hue < hi)) begin
                hit_d[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    // Register the match so band_hit lines up with the final pipeline stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_hit <= '0;
        end else begin
            band_hit <= hit_d;
        end
    end

    // Hold the most recent hue that landed in each band.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_last_hue <= '0;
        end else begin
            for (int i = 0; i < HUE_BANDS; i++) begin
                if (band_hit[i]) begin
                    band_last_hue[i*HUE_W +: HUE_W] <= hue;
                end
            end
        end
    end

`ifdef RGB2HSV_BAND_STATS_EN
    logic [CNT_W-1:0] cnt_q [HUE_BANDS];
    logic             ovs_prev_q;
    logic             armed_q;
    logic             ovs_rise;

    assign ovs_rise = out_vsync && !ovs_prev_q;

    // Per-frame counting; the first frame after reset is partial, so it is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovs_prev_q  <= 1'b0;
            armed_q     <= 1'b0;
            stats_valid <= 1'b0;
            band_count  <= '0;
            for (int i = 0; i < HUE_BANDS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ovs_prev_q  <= out_vsync;
            stats_valid <= 1'b0;
            if (ovs_rise) begin
                armed_q <= 1'b1;
                if (armed_q) begin
                    stats_valid <= 1'b1;
                    for (int i = 0; i < HUE_BANDS; i++) begin
                        band_count[i*CNT_W +: CNT_W] <= cnt_q[i];
                    end
                end
            end
            for (int i = 0; i < HUE_BANDS; i++) begin
                if (ovs_rise) begin
                    // A hit on the copy cycle belongs to the new frame.
                    cnt_q[i] <= (out_de && band_hit[i]) ? CNT_W'(1) : '0;
                end else if (out_de && band_hit[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = ^{out_vsync, out_de};
    assign band_count   = '0;
    assign stats_valid  = 1'b0;
`endif

endmodule

// File: rtl/rgb2hsv_pipe.sv
// Four-stage RGB to HSV converter with delay-matched syncs and hue band
// classification. Optional per-band frame statistics: RGB2HSV_BAND_STATS_EN.
module rgb2hsv_pipe
    import rgb2hsv_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned HUE_BANDS = 3,
    parameter int unsigned CNT_W     = 22
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_vsync,
    input  logic                         in_hsync,
    input  logic                         in_de,
    input  logic [3*DW-1:0]              in_data,
    input  logic [HUE_BANDS*HUE_W-1:0]   band_lo,
    input  logic [HUE_BANDS*HUE_W-1:0]   band_hi,
    output logic                         out_vsync,
    output logic                         out_hsync,
    output logic                         out_de,
    output logic [3*DW-1:0]              out_data,
    output logic [HUE_W-1:0]             hue,
    output logic [DW:0]                  sat,
    output logic [DW-1:0]                val,
    output logic [HUE_BANDS-1:0]         band_hit,
    output logic [HUE_BANDS*HUE_W-1:0]   band_last_hue,
    output logic [HUE_BANDS*CNT_W-1:0]   band_count,
    output logic                         stats_valid
);

    localparam int unsigned NUM_W = DW + 6;

    // Stage 1 registers
    logic [DW-1:0] r1, g1, b1;
    logic          vs1, hs1, de1;

    // Stage 2 registers
    max_sel_e      sel2;
    logic [DW-1:0] max2, delta2;
    logic [NUM_W-1:0] num2;
    logic          xge2;
    logic          vs2, hs2, de2;

    // Stage 3 registers
    logic [HUE_W-1:0] hue3;
    logic [DW:0]      sat3;
    logic [DW-1:0]    val3;
    logic             vs3, hs3, de3;

    // Input register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1  <= '0;
            g1  <= '0;
            b1  <= '0;
            vs1 <= 1'b0;
            hs1 <= 1'b0;
            de1 <= 1'b0;
        end else begin
            r1  <= in_data[3*DW-1:2*DW];
            g1  <= in_data[2*DW-1:DW];
            b1  <= in_data[DW-1:0];
            vs1 <= in_vsync;
            hs1 <= in_hsync;
            de1 <= in_de;
        end
    end

    max_sel_e         sel_d;
    logic [DW-1:0]    mx_d, mn_d, x_d, y_d, diff_d;
    logic             xge_d;
    logic [NUM_W-1:0] num_d;

    // Pick max channel and the (x, y) pair whose difference drives the hue offset.
    always_comb begin
        sel_d = SelR;
        mx_d  = r1;
        x_d   = g1;
        y_d   = b1;
        if (r1 >= g1 && r1 >= b1) begin
            sel_d = SelR;
            mx_d  = r1;
            x_d   = g1;
            y_d   = b1;
        end else if (g1 >= b1) begin
            sel_d = SelG;
            mx_d  = g1;
            x_d   = b1;
            y_d   = r1;
        end else begin
            sel_d = SelB;
            mx_d  = b1;
            x_d   = r1;
            y_d   = g1;
        end
        mn_d = r1;
        if (g1 < mn_d) mn_d = g1;
        if (b1 < mn_d) mn_d = b1;
        xge_d  = (x_d >= y_d);
        diff_d = xge_d ? (x_d - y_d) : (y_d - x_d);
        num_d  = NUM_W'(diff_d) * NUM_W'(HUE_60);
    end

    // Stage 2: max, delta and the pre-scaled hue numerator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel2   <= SelR;
            max2   <= '0;
            delta2 <= '0;
            num2   <= '0;
            xge2   <= 1'b0;
            vs2    <= 1'b0;
            hs2    <= 1'b0;
            de2    <= 1'b0;
        end else begin
            sel2   <= sel_d;
            max2   <= mx_d;
            delta2 <= mx_d - mn_d;
            num2   <= num_d;
            xge2   <= xge_d;
            vs2    <= vs1;
            hs2    <= hs1;
            de2    <= de1;
        end
    end

    logic [HUE_W-1:0] q_d, h_d;
    logic [DW:0]      s_d;

    // Divides and sector select; grey pixels (delta 0) report hue 0.
    always_comb begin
        q_d = (delta2 == '0) ? '0 : HUE_W'(num2 / NUM_W'(delta2));
        case (sel2)
            SelR:    h_d = xge2 ? q_d : (HUE_360 - q_d);
            SelG:    h_d = xge2 ? (HUE_120 + q_d) : (HUE_120 - q_d);
            SelB:    h_d = xge2 ? (HUE_240 + q_d) : (HUE_240 - q_d);
            default: h_d = '0;
        endcase
        if (h_d == HUE_360 || delta2 == '0) begin
            h_d = '0;
        end
        s_d = (max2 == '0) ? '0 : (DW+1)'({delta2, {DW{1'b0}}} / (2*DW)'(max2));
    end

    // Stage 3: hue, saturation and value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue3 <= '0;
            sat3 <= '0;
            val3 <= '0;
            vs3  <= 1'b0;
            hs3  <= 1'b0;
            de3  <= 1'b0;
        end else begin
            hue3 <= h_d;
            sat3 <= s_d;
            val3 <= max2;
            vs3  <= vs2;
            hs3  <= hs2;
            de3  <= de2;
        end
    end

    logic [DW-1:0] hs_d;
    logic [DW-1:0] sat_clip_d;

    // Display scaling; full saturation (2^DW) clips to the field maximum.
    always_comb begin
        hs_d       = DW'(hue_scale(hue3, DW));
        sat_clip_d = sat3[DW] ? {DW{1'b1}} : sat3[DW-1:0];
    end

    // Stage 4: output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hue       <= '0;
            sat       <= '0;
            val       <= '0;
            out_data  <= '0;
            out_vsync <= 1'b0;
            out_hsync <= 1'b0;
            out_de    <= 1'b0;
        end else begin
            hue       <= hue3;
            sat       <= sat3;
            val       <= val3;
            out_data  <= {val3, sat_clip_d, hs_d};
            out_vsync <= vs3;
            out_hsync <= hs3;
            out_de    <= de3;
        end
    end

    hsv_band_stats #(
        .HUE_BANDS (HUE_BANDS),
        .CNT_W     (CNT_W)
    ) u_band_stats (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_vsync      (in_vsync),
        .band_lo       (band_lo),
        .band_hi       (band_hi),
        .cmp_de        (de3),
        .cmp_hue       (hue3),
        .hue           (hue),
        .out_vsync     (out_vsync),
        .out_de        (out_de),
        .band_hit      (band_hit),
        .band_last_hue (band_last_hue),
        .band_count    (band_count),
        .stats_valid   (stats_valid)
    );

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// Directed bench for rgb2hsv_pipe: vector table, streaming, sync delay,
// band classification and frame statistics (both builds of RGB2HSV_BAND_STATS_EN).
module tb_rgb2hsv_pipe;

`ifdef RGB2HSV_BAND_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vsync, in_hsync, in_de;
    logic [23:0] in_data;
    logic [26:0] band_lo, band_hi;

    logic        out_vsync, out_hsync, out_de, stats_valid;
    logic [23:0] out_data;
    logic [8:0]  hue;
    logic [8:0]  sat;
    logic [7:0]  val;
    logic [2:0]  band_hit;
    logic [26:0] band_last_hue;
    logic [65:0] band_count;

    logic        s_vsync, s_hsync, s_de, s_stats_valid;
    logic [23:0] s_data;
    logic [8:0]  s_hue;
    logic [8:0]  s_sat;
    logic [7:0]  s_val;
    logic [2:0]  s_band_hit;
    logic [26:0] s_last_hue;
    logic [11:0] s_band_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rgb2hsv_pipe #(.DW(8), .HUE_BANDS(3), .CNT_W(22)) dut (
        .clk (clk), .rst_n (rst_n),
        .in_vsync (in_vsync), .in_hsync (in_hsync), .in_de (in_de), .in_data (in_data),
        .band_lo (band_lo), .band_hi (band_hi),
        .out_vsync (out_vsync), .out_hsync (out_hsync), .out_de (out_de),
        .out_data (out_data), .hue (hue), .sat (sat), .val (val),
        .band_hit (band_hit), .band_last_hue (band_last_hue),
        .band_count (band_count), .stats_valid (stats_valid)
    );

    rgb2hsv_pipe #(.DW(8), .HUE_BANDS(3), .CNT_W(4)) dut_small (
        .clk (clk), .rst_n (rst_n),
        .in_vsync (in_vsync), .in_hsync (in_hsync), .in_de (in_de), .in_data (in_data),
        .band_lo (band_lo), .band_hi (band_hi),
        .out_vsync (s_vsync), .out_hsync (s_hsync), .out_de (s_de),
        .out_data (s_data), .hue (s_hue), .sat (s_sat), .val (s_val),
        .band_hit (s_band_hit), .band_last_hue (s_last_hue),
        .band_count (s_band_count), .stats_valid (s_stats_valid)
    );

    // stats_valid pulse monitor (count of pulses and longest run)
    int sv_pulses = 0;
    int sv_run    = 0;
    int sv_maxrun = 0;
    bit sv_prev   = 1'b0;
    always @(negedge clk) begin
        sv_prev   <= stats_valid;
        sv_pulses <= sv_pulses + ((stats_valid && !sv_prev) ? 1 : 0);
        sv_run    <= stats_valid ? sv_run + 1 : 0;
        if (stats_valid && (sv_run + 1 > sv_maxrun)) sv_maxrun <= sv_run + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: vsync, na pixels of hue 40, nb pixels of hue 120, then idle.
    task automatic frame(input int na, input int nb, input bit chk, input bit scramble);
        logic [26:0] lo_s, hi_s;
        lo_s = band_lo;
        hi_s = band_hi;
        in_vsync = 1'b1;
        tick();
        tick();
        in_vsync = 1'b0;
        tick();
        if (scramble) begin
            band_lo = '0;
            band_hi = '0;
        end
        for (int k = 0; k < na + nb + 4; k++) begin
            if (k < na) begin
                in_de = 1'b1; in_data = 24'hFFAA00;
            end else if (k < na + nb) begin
                in_de = 1'b1; in_data = 24'h00FF00;
            end else begin
                in_de = 1'b0; in_data = '0;
            end
            tick();
            if (chk && k >= 3) check("band_hit_stream", band_hit, (k - 3 < na) ? 3'b001 : 3'b000);
        end
        in_de = 1'b0;
        in_data = '0;
        repeat (6) tick();
        band_lo = lo_s;
        band_hi = hi_s;
    endtask

    typedef struct {
        logic [23:0] rgb;
        logic [8:0]  h;
        logic [8:0]  s;
        logic [7:0]  v;
        logic [23:0] d;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{24'hFF0000, 9'd0,   9'd256, 8'd255, 24'hFFFF00};
        vecs[1]  = '{24'h00FF00, 9'd120, 9'd256, 8'd255, 24'hFFFF55};
        vecs[2]  = '{24'h0000FF, 9'd240, 9'd256, 8'd255, 24'hFFFFAA};
        vecs[3]  = '{24'hFF0080, 9'd330, 9'd256, 8'd255, 24'hFFFFEA};
        vecs[4]  = '{24'h646464, 9'd0,   9'd0,   8'd100, 24'h640000};
        vecs[5]  = '{24'hFFAA00, 9'd40,  9'd256, 8'd255, 24'hFFFF1C};
        vecs[6]  = '{24'h804020, 9'd20,  9'd192, 8'd128, 24'h80C00E};
        vecs[7]  = '{24'hFF0001, 9'd0,   9'd256, 8'd255, 24'hFFFF00};
        vecs[8]  = '{24'hFF0005, 9'd359, 9'd256, 8'd255, 24'hFFFFFF};
        vecs[9]  = '{24'h80FF00, 9'd90,  9'd256, 8'd255, 24'hFFFF40};
        vecs[10] = '{24'h0040FF, 9'd225, 9'd256, 8'd255, 24'hFFFFA0};
        vecs[11] = '{24'hFFFF00, 9'd60,  9'd256, 8'd255, 24'hFFFF2A};
        vecs[12] = '{24'h000000, 9'd0,   9'd0,   8'd0,   24'h000000};

        rst_n = 1'b0;
        in_vsync = 1'b0; in_hsync = 1'b0; in_de = 1'b0; in_data = '0;
        band_lo = '0; band_hi = '0;
        repeat (3) tick();
        check("reset_out", {out_vsync, out_hsync, out_de, out_data, hue, sat, val}, '0);
        check("reset_band", {band_hit, band_last_hue, band_count, stats_valid}, '0);
        rst_n = 1'b1;
        tick();

        // Single pixels, checked exactly LAT cycles later
        for (int i = 0; i < NV; i++) begin
            in_data = vecs[i].rgb;
            in_de = 1'b1;
            tick();
            in_de = 1'b0;
            in_data = '0;
            repeat (3) tick();
            check($sformatf("hue[%0d]", i), hue, vecs[i].h);
            check($sformatf("sat[%0d]", i), sat, vecs[i].s);
            check($sformatf("val[%0d]", i), val, vecs[i].v);
            check($sformatf("out_data[%0d]", i), out_data, vecs[i].d);
            check($sformatf("de_hit[%0d]", i), {out_de, band_hit}, 4'b1000);
        end

        // Back-to-back stream: one pixel per clock
        for (int k = 0; k < NV + 3; k++) begin
            if (k < NV) begin
                in_de = 1'b1; in_data = vecs[k].rgb;
            end else begin
                in_de = 1'b0; in_data = '0;
            end
            tick();
            if (k >= 3) begin
                check($sformatf("stream_hue[%0d]", k - 3), hue, vecs[k-3].h);
                check($sformatf("stream_data[%0d]", k - 3), out_data, vecs[k-3].d);
            end
        end
        in_de = 1'b0;
        in_data = '0;
        tick();

        // Sync delay: hsync pulse appears after exactly 4 clocks
        in_hsync = 1'b1;
        tick();
        in_hsync = 1'b0;
        tick();
        tick();
        check("hsync_early", out_hsync, 1'b0);
        tick();
        check("hsync_lat", out_hsync, 1'b1);
        tick();
        check("hsync_after", out_hsync, 1'b0);
        repeat (4) tick();

        // Bands (30,45), (60,80), (100,120)
        band_lo = {9'd100, 9'd60, 9'd30};
        band_hi = {9'd120, 9'd80, 9'd45};
        frame(10, 5, 1'b1, 1'b1);
        check("frame1_no_pulse", sv_pulses, 0);
        check("last_hue", band_last_hue, {9'd0, 9'd0, 9'd40});
        frame(10, 5, 1'b0, 1'b0);
        check("frame2_count", band_count, STATS ? {22'd0, 22'd0, 22'd10} : 66'd0);
        check("frame2_small", s_band_count, STATS ? {4'd0, 4'd0, 4'd10} : 12'd0);
        check("frame2_pulses", sv_pulses, STATS ? 1 : 0);
        frame(20, 0, 1'b0, 1'b0);
        frame(0, 0, 1'b0, 1'b0);
        check("frame3_count", band_count, STATS ? {22'd0, 22'd0, 22'd20} : 66'd0);
        check("frame3_sat", s_band_count, STATS ? {4'd0, 4'd0, 4'd15} : 12'd0);
        check("pulses_3", sv_pulses, STATS ? 3 : 0);
        check("pulse_width", sv_maxrun, STATS ? 1 : 0);

        // Reset in the middle of a frame
        in_vsync = 1'b1;
        tick();
        tick();
        in_vsync = 1'b0;
        in_de = 1'b1;
        in_data = 24'hFFAA00;
        repeat (6) tick();
        rst_n = 1'b0;
        #2;
        check("midrst_out", {out_vsync, out_hsync, out_de, out_data, hue, sat, val}, '0);
        check("midrst_band", {band_hit, band_last_hue, band_count, stats_valid}, '0);
        check("midrst_small", {s_band_count, s_stats_valid, s_last_hue}, '0);
        in_de = 1'b0;
        in_data = '0;
        tick();
        rst_n = 1'b1;
        tick();
        frame(10, 0, 1'b0, 1'b0);
        check("post_rst_no_pulse", sv_pulses, STATS ? 3 : 0);
        check("post_rst_count", band_count, '0);
        frame(0, 0, 1'b0, 1'b0);
        check("post_rst_rearm", band_count, STATS ? {22'd0, 22'd0, 22'd10} : 66'd0);
        check("post_rst_pulses", sv_pulses, STATS ? 4 : 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb2hsv_pipe.md
# rgb2hsv_pipe

Parametrised, fully pipelined RGB→HSV converter for the video path. It accepts one packed RGB pixel per clock with vsync/hsync/de and emits HSV components and an HSV-packed display word, with syncs delay-matched. It classifies each pixel's hue against HUE_BANDS runtime-programmable bands and, optionally, accumulates per-frame band pixel counts for the downstream detection logic.

## Interface
- DW, 8: bits per colour component.
- HUE_BANDS, 3: number of hue bands.
- CNT_W, 22: per-band pixel counter width.
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- in_vsync / in_hsync / in_de  in  1 each  input syncs; vsync is an active-high frame-start level.
- in_data  in  3*DW  {R,G,B}, with R in the MSBs.
- band_lo / band_hi  in  HUE_BANDS*9 each  band bounds; band i occupies [9i+8:9i].
- out_vsync / out_hsync / out_de  out  1 each  syncs delayed by LAT.
- out_data  out  3*DW  display word {V, S_sat, H_scaled}.
- hue  out  9  0..359.
- sat  out  DW+1  0..2^DW.
- val  out  DW  max(R,G,B).
- band_hit  out  HUE_BANDS  one-hot band match, aligned with out_de.
- band_last_hue  out  HUE_BANDS*9  last hue that hit each band.
- band_count  out  HUE_BANDS*CNT_W  latched per-frame counts.
- stats_valid  out  1  single-cycle pulse when band_count updates.

## Operation
- Min/max/delta:
  - max and min are taken over R, G, B; delta = max − min.
  - Tie priority for the max channel is R, then G, then B.
- Hue:
  - If delta = 0, H = 0.
  - Otherwise q = floor(60·|x−y| / delta), using a (DW+6)-bit numerator. (x, y) is (G, B) for an R max, (B, R) for a G max, and (R, G) for a B max.
  - R max: H = q if G ≥ B, else 360 − q; a result of 360 maps to 0.
  - G max: H = 120 + q if B ≥ R, else 120 − q.
  - B max: H = 240 + q if R ≥ G, else 240 − q.
- Saturation: S = floor(delta·2^DW / max), with S = 0 when max = 0.
- Value: V = max.
- out_data:
  - V field: V.
  - S_sat field: min(S, 2^DW−1).
  - H_scaled field: 2^DW−1 if H ≥ 359, else floor(H·2^DW/360).
- Band match:
  - Band i matches when out_de = 1 and band_lo_i < H < band_hi_i; both bounds are strict.
  - If several bands match, the lowest index wins, so band_hit stays one-hot or zero.
  - band_lo/band_hi are captured into shadow registers on the in_vsync rising edge. Bounds therefore change only at frame boundaries.
  - Shadow registers reset to 0, which leaves no band able to match.
- band_last_hue_i loads H on every hit of band i and otherwise holds its value.
- Per-frame statistics:
  - Counters run on out_vsync, out_de and band_hit.
  - Each hit increments that band's counter, saturating at 2^CNT_W−1.
  - On an out_vsync rising edge, counters copy into band_count, stats_valid pulses, and counters restart.
  - A hit on the same cycle as the copy counts into the new frame, so that counter restarts at 1.
  - The first out_vsync rise after reset only clears the counters: no copy, no pulse. This suppresses the partial frame.

## Timing
- LAT = 4 cycles from in_* to all out_* (hue, sat, val, out_data, band_hit, syncs):
  - stage 1: input register.
  - stage 2: max/min/delta and scaled differences.
  - stage 3: divides and hue select.
  - stage 4: display scaling and band compare.
- band_last_hue updates 1 cycle after band_hit.
- stats_valid is asserted on the cycle after the out_vsync rise, and band_count is valid on that same cycle.
- Throughput is 1 pixel per clock with no stalls.
- Reset value of every output and internal register is 0.
- Reset asserted mid-frame flushes the pipeline, clears counters and re-arms first-frame suppression.

## Configuration
- RGB2HSV_BAND_STATS_EN:
  - Defined: per-band counters, band_count and stats_valid are implemented as described.
  - Undefined: the counters are removed; band_count and stats_valid are tied to 0. band_hit and band_last_hue remain functional.
- Ports are identical in both builds.

## Structure
- Package rgb2hsv_pkg holds:
  - LAT = 4 and HUE_W = 9.
  - Constants HUE_60, HUE_120, HUE_240, HUE_360.
  - Function hue_scale (H → DW-bit display value).
- One sub-module, hsv_band_stats. It contains shadow bounds, band compare, last-hue hold and the counters; only the counters are under the macro.

## Test plan
- in_data FF0000 → after 4 cycles:
  - H=0, S=256, V=255; out_data FFFF00.
- 00FF00 → H=120, out_data FFFF55.
- 0000FF → H=240, out_data FFFFAA.
- FF0080 → H=330, S=256, out_data FFFFEA.
- 646464 → H=0, S=0, V=100, band_hit=0.
- Bands (30,45), (60,80), (100,120); frame 1 then frame 2, each with 10 px FFAA00 (H=40) and 5 px 00FF00 (H=120):
  - No stats_valid after frame 1 (post-reset suppression).
  - After frame 2: band_count = {0,0,10}, stats_valid high for exactly 1 cycle.
  - band_last_hue_0 = 40.
- CNT_W=4, 20 hits in band 0 → count 15.
- Reset mid-frame → all outputs 0, next out_vsync rise gives no stats_valid.
- Build without RGB2HSV_BAND_STATS_EN → band_count and stats_valid stay 0, band_hit unchanged.
